// File: rtl/if_id_register.sv
// rtl/if_id_register.sv - IF/ID pipeline register with stall, flush, debug step, HALT freeze and stall counter
module if_id_register #(
    parameter int                    SIZE_PC    = 32,
    parameter int                    SIZE_INSTR = 32,
    parameter logic [SIZE_INSTR-1:0] NOP_INSTR  = 32'h00000000,
    parameter logic [SIZE_INSTR-1:0] HALT_INSTR = 32'hFFFFFFFF,
    parameter int                    SIZE_CNT   = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic                  i_stall,
    input  logic                  i_flush,
    input  logic                  i_valid,
    input  logic [SIZE_PC-1:0]    i_pc_plus4,
    input  logic [SIZE_INSTR-1:0] i_instruction,
    output logic [SIZE_PC-1:0]    o_pc_plus4,
    output logic [SIZE_INSTR-1:0] o_instruction,
    output logic                  o_valid,
    output logic                  o_halt,
    output logic [SIZE_CNT-1:0]   o_stall_cycles
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [SIZE_PC-1:0]    r_pc_plus4;
    logic [SIZE_PC-1:0]    w_pc_plus4_next;
    logic [SIZE_INSTR-1:0] r_instruction;
    logic [SIZE_INSTR-1:0] w_instruction_next;
    logic                  r_valid;
    logic                  w_valid_next;
    logic                  r_halt;
    logic                  w_halt_next;
    logic [SIZE_CNT-1:0]   r_stall_cycles;
    logic [SIZE_CNT-1:0]   w_stall_cycles_next;
    logic                  w_cnt_at_max;
    logic                  w_is_halt;

    assign w_cnt_at_max = (r_stall_cycles == {SIZE_CNT{1'b1}});
    // Only a real, loaded instruction may halt; flushed or invalid HALT words are ignored.
    assign w_is_halt    = i_valid && (i_instruction == HALT_INSTR);

    // Next-state and next-register values; every path holds unless RUN and enabled.
    always_comb begin
        w_state_next        = r_state;
        w_pc_plus4_next     = r_pc_plus4;
        w_instruction_next  = r_instruction;
        w_valid_next        = r_valid;
        w_halt_next         = r_halt;
        w_stall_cycles_next = r_stall_cycles;
        if (r_state == ST_RUN && i_enable) begin
            if (i_flush) begin
                // Flush outranks stall: the wrong-path instruction becomes a bubble.
                w_pc_plus4_next    = i_pc_plus4;
                w_instruction_next = NOP_INSTR;
                w_valid_next       = 1'b0;
            end else if (i_stall) begin
                if (!w_cnt_at_max) begin
                    w_stall_cycles_next = r_stall_cycles + {{(SIZE_CNT-1){1'b0}}, 1'b1};
                end
            end else begin
                w_pc_plus4_next    = i_pc_plus4;
                w_instruction_next = i_valid ? i_instruction : NOP_INSTR;
                w_valid_next       = i_valid;
                if (w_is_halt) begin
                    // HALT still travels to ID so downstream stages can drain.
                    w_halt_next  = 1'b1;
                    w_state_next = ST_HALTED;
                end
            end
        end
    end

    // State and pipeline registers; reset overrides everything, including HALTED.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= ST_RUN;
            r_pc_plus4     <= '0;
            r_instruction  <= NOP_INSTR;
            r_valid        <= 1'b0;
            r_halt         <= 1'b0;
            r_stall_cycles <= '0;
        end else begin
            r_state        <= w_state_next;
            r_pc_plus4     <= w_pc_plus4_next;
            r_instruction  <= w_instruction_next;
            r_valid        <= w_valid_next;
            r_halt         <= w_halt_next;
            r_stall_cycles <= w_stall_cycles_next;
        end
    end

    assign o_pc_plus4     = r_pc_plus4;
    assign o_instruction  = r_instruction;
    assign o_valid        = r_valid;
    assign o_halt         = r_halt;
    assign o_stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_if_id_register.sv
// tb/tb_if_id_register.sv - self-checking bench for if_id_register
module tb_if_id_register;

    localparam logic [31:0] NOP  = 32'h00000000;
    localparam logic [31:0] HALT = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] pc4 = '0;
    logic [31:0] instr = '0;
    logic [31:0] o_pc4;
    logic [31:0] o_instr;
    logic        o_valid;
    logic        o_halt;
    logic [15:0] o_cnt;

    int checks = 0;
    int failures = 0;

    // Reference model state, derived from the behavioural rules.
    logic [31:0] m_pc4 = '0;
    logic [31:0] m_instr = NOP;
    logic        m_valid = 1'b0;
    logic        m_halt = 1'b0;
    int          m_cnt = 0;

    always #5 clk = ~clk;

    if_id_register dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_enable      (en),
        .i_stall       (stall),
        .i_flush       (flush),
        .i_valid       (valid),
        .i_pc_plus4    (pc4),
        .i_instruction (instr),
        .o_pc_plus4    (o_pc4),
        .o_instruction (o_instr),
        .o_valid       (o_valid),
        .o_halt        (o_halt),
        .o_stall_cycles(o_cnt)
    );

    task automatic tick(input logic r, input logic e, input logic s, input logic f,
                        input logic v, input logic [31:0] p, input logic [31:0] ins);
        rst = r; en = e; stall = s; flush = f; valid = v; pc4 = p; instr = ins;
        @(posedge clk);
        if (r) begin
            m_pc4 = '0; m_instr = NOP; m_valid = 1'b0; m_halt = 1'b0; m_cnt = 0;
        end else if (m_halt || !e) begin
            // frozen or debug-held
        end else if (f) begin
            m_pc4 = p; m_instr = NOP; m_valid = 1'b0;
        end else if (s) begin
            m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
        end else begin
            m_pc4 = p; m_valid = v; m_instr = v ? ins : NOP;
            if (v && ins == HALT) m_halt = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        tick(1, 1, 1, 1, 1, 32'h1234, HALT);
        checks++;
        if ({o_pc4, o_instr, o_valid, o_halt, o_cnt} !== {32'h0, NOP, 1'b0, 1'b0, 16'h0}) begin
            failures++;
            $display("FAIL reset: got pc4=%h instr=%h valid=%b halt=%b cnt=%h, want 0/0/0/0/0",
                     o_pc4, o_instr, o_valid, o_halt, o_cnt);
        end
    endtask

    task automatic test_load();
        tick(0, 1, 0, 0, 1, 32'd4, 32'h2001_0005);
        checks++;
        if ({o_pc4, o_instr, o_valid} !== {32'd4, 32'h20010005, 1'b1}) begin
            failures++;
            $display("FAIL load: got pc4=%h instr=%h valid=%b, want 4/20010005/1", o_pc4, o_instr, o_valid);
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            tick(0, 1, 1, 0, 1, $urandom, $urandom);
            checks++;
            if ({o_pc4, o_instr, o_valid} !== {32'd4, 32'h20010005, 1'b1}) begin
                failures++;
                $display("FAIL stall_hold: got pc4=%h instr=%h valid=%b, want 4/20010005/1",
                         o_pc4, o_instr, o_valid);
            end
        end
        checks++;
        if (o_cnt !== 16'd3) begin
            failures++;
            $display("FAIL stall_count: got %0d want 3", o_cnt);
        end
    endtask

    task automatic test_flush_stall();
        tick(0, 1, 1, 1, 1, 32'd8, 32'h8C22_0000);
        checks++;
        if ({o_pc4, o_instr, o_valid, o_cnt} !== {32'd8, NOP, 1'b0, 16'd3}) begin
            failures++;
            $display("FAIL flush_over_stall: got pc4=%h instr=%h valid=%b cnt=%0d, want 8/0/0/3",
                     o_pc4, o_instr, o_valid, o_cnt);
        end
    endtask

    task automatic test_enable();
        tick(0, 0, 0, 1, 1, 32'd100, 32'hAAAA_5555);
        checks++;
        if ({o_pc4, o_instr, o_valid, o_cnt} !== {32'd8, NOP, 1'b0, 16'd3}) begin
            failures++;
            $display("FAIL enable_hold: got pc4=%h instr=%h valid=%b cnt=%0d, want 8/0/0/3",
                     o_pc4, o_instr, o_valid, o_cnt);
        end
        tick(0, 0, 1, 0, 1, 32'd100, 32'hAAAA_5555);
        checks++;
        if (o_cnt !== 16'd3) begin
            failures++;
            $display("FAIL enable_no_count: got %0d want 3", o_cnt);
        end
        tick(0, 1, 0, 0, 1, 32'd12, 32'h0022_1820);
        checks++;
        if ({o_pc4, o_instr, o_valid} !== {32'd12, 32'h00221820, 1'b1}) begin
            failures++;
            $display("FAIL reenable_load: got pc4=%h instr=%h valid=%b, want c/00221820/1",
                     o_pc4, o_instr, o_valid);
        end
    endtask

    task automatic test_halt();
        tick(0, 1, 0, 0, 1, 32'd16, HALT);
        checks++;
        if ({o_pc4, o_instr, o_valid, o_halt} !== {32'd16, HALT, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL halt_load: got pc4=%h instr=%h valid=%b halt=%b, want 10/ffffffff/1/1",
                     o_pc4, o_instr, o_valid, o_halt);
        end
        for (int i = 0; i < 6; i++) begin
            tick(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom);
            checks++;
            if ({o_pc4, o_instr, o_valid, o_halt, o_cnt} !== {32'd16, HALT, 1'b1, 1'b1, 16'd3}) begin
                failures++;
                $display("FAIL halt_frozen: got pc4=%h instr=%h valid=%b halt=%b cnt=%0d",
                         o_pc4, o_instr, o_valid, o_halt, o_cnt);
            end
        end
        tick(1, 1, 0, 0, 1, 32'd20, HALT);
        checks++;
        if ({o_pc4, o_instr, o_valid, o_halt, o_cnt} !== {32'h0, NOP, 1'b0, 1'b0, 16'h0}) begin
            failures++;
            $display("FAIL halt_reset: got pc4=%h instr=%h valid=%b halt=%b cnt=%0d",
                     o_pc4, o_instr, o_valid, o_halt, o_cnt);
        end
    endtask

    task automatic test_halt_blocked();
        tick(0, 1, 0, 1, 1, 32'd24, HALT);
        checks++;
        if ({o_halt, o_instr, o_valid} !== {1'b0, NOP, 1'b0}) begin
            failures++;
            $display("FAIL halt_flushed: got halt=%b instr=%h valid=%b, want 0/0/0", o_halt, o_instr, o_valid);
        end
        tick(0, 1, 0, 0, 0, 32'd28, HALT);
        checks++;
        if ({o_halt, o_instr, o_valid, o_pc4} !== {1'b0, NOP, 1'b0, 32'd28}) begin
            failures++;
            $display("FAIL halt_invalid: got halt=%b instr=%h valid=%b pc4=%h, want 0/0/0/1c",
                     o_halt, o_instr, o_valid, o_pc4);
        end
        // Next valid load must still work normally, proving no hidden halt.
        tick(0, 1, 0, 0, 1, 32'd32, 32'h1234_5678);
        checks++;
        if ({o_halt, o_instr, o_valid} !== {1'b0, 32'h12345678, 1'b1}) begin
            failures++;
            $display("FAIL after_blocked_halt: got halt=%b instr=%h valid=%b", o_halt, o_instr, o_valid);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 65535; i++) tick(0, 1, 1, 0, 1, $urandom, $urandom);
        checks++;
        if (o_cnt !== 16'hFFFF) begin
            failures++;
            $display("FAIL sat_reach: got %h want ffff", o_cnt);
        end
        for (int i = 0; i < 4; i++) tick(0, 1, 1, 0, 1, $urandom, $urandom);
        checks++;
        if ({o_cnt, o_instr, o_pc4} !== {16'hFFFF, 32'h12345678, 32'd32}) begin
            failures++;
            $display("FAIL sat_hold: got cnt=%h instr=%h pc4=%h, want ffff/12345678/20", o_cnt, o_instr, o_pc4);
        end
    endtask

    task automatic test_random();
        logic [31:0] ri;
        for (int i = 0; i < 600; i++) begin
            ri = ($urandom_range(0, 19) == 0) ? HALT : $urandom;
            tick(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 7) != 0),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 6) == 0),
                 1'($urandom_range(0, 4) != 0), $urandom, ri);
            checks++;
            if ({o_pc4, o_instr, o_valid, o_halt, o_cnt} !== {m_pc4, m_instr, m_valid, m_halt, 16'(m_cnt)}) begin
                failures++;
                $display("FAIL random[%0d]: got pc4=%h instr=%h valid=%b halt=%b cnt=%0d, want %h/%h/%b/%b/%0d",
                         i, o_pc4, o_instr, o_valid, o_halt, o_cnt, m_pc4, m_instr, m_valid, m_halt, m_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_stall();
        test_flush_stall();
        test_enable();
        test_halt();
        test_halt_blocked();
        test_saturation();
        tick(1, 1, 0, 0, 0, 0, 0);
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
